l1_l2_arbiter: RTL
==================

Name: l1_l2_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, in front of the single unified L2 port.
- Accepts 128-bit line-fill reads from the icache, and line reads and write-backs from the dcache.
- Grants one requester at a time and registers that requester's address and write data.
- Drives a single L2 transaction and routes the L2 response back to the granted requester only.
- Arbitration is fair alternating-priority when both caches request in the same cycle.

Parameters:
- ADDR_WIDTH, 16, width of the byte address carried to L2 (lc3b_word).
- LINE_WIDTH, 128, width of one L1 line (lc3b_L1_line).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- icache_L2_read  input  1  icache line-fill request; held until icache_L2_resp.
- icache_L2_address  input  ADDR_WIDTH  icache line address.
- icache_L2_rdata  output  LINE_WIDTH  line returned to icache.
- icache_L2_resp  output  1  icache transaction complete.
- dcache_L2_read  input  1  dcache line-fill request; held until dcache_L2_resp.
- dcache_L2_write  input  1  dcache write-back request; held until dcache_L2_resp.
- dcache_L2_address  input  ADDR_WIDTH  dcache line address.
- dcache_L2_wdata  input  LINE_WIDTH  dcache write-back line.
- dcache_L2_rdata  output  LINE_WIDTH  line returned to dcache.
- dcache_L2_resp  output  1  dcache transaction complete.
- L2_read  output  1  read request to L2.
- L2_write  output  1  write request to L2.
- L2_address  output  ADDR_WIDTH  registered address to L2.
- L2_wdata  output  LINE_WIDTH  registered write data to L2.
- L2_rdata  input  LINE_WIDTH  L2 read data, valid with L2_resp.
- L2_resp  input  1  L2 transaction complete (single-cycle pulse).

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Priority bit prio: 0 favours icache, 1 favours dcache.
- Reset: state=IDLE, prio=0, addr_reg=0, wdata_reg=0, is_write=0. All outputs are 0 while in IDLE and during reset.
- IDLE: samples requests each cycle.
  - Only icache requesting -> SERVE_I.
  - Only dcache requesting (read or write) -> SERVE_D.
  - Both requesting -> the side chosen by prio.
  - On grant: latch the granter's address into addr_reg. For dcache, also latch wdata into wdata_reg and dcache_L2_write into is_write.
  - prio is set to point at the non-granted side after every grant, contested or not.
- SERVE_I:
  - L2_read=1, L2_write=0, L2_address=addr_reg.
  - On L2_resp: icache_L2_resp=1 and icache_L2_rdata=L2_rdata combinationally in the same cycle; next state IDLE.
- SERVE_D:
  - L2_read=!is_write, L2_write=is_write, L2_address=addr_reg, L2_wdata=wdata_reg.
  - On L2_resp: dcache_L2_resp=1 and dcache_L2_rdata=L2_rdata in the same cycle; next state IDLE.
- Non-granted side: its resp is 0. Its rdata is driven from L2_rdata, but meaning is defined only with its resp.
- Latency:
  - Request seen in IDLE at cycle N -> L2 request asserted at N+1.
  - L2_resp at cycle M -> requester resp at M.
  - Earliest next grant is decided at M+1, with the L2 request at M+2. One mandatory IDLE cycle between transactions.
- dcache_L2_read and dcache_L2_write both high: treated as write (is_write=1). The bench flags this as a protocol error.
- Requester drops its request mid-transaction: the arbiter still completes the L2 transaction and pulses resp. The requester ignores it.
- Request inputs changing while granted have no effect on L2 outputs, because they are driven from the registered copies.
- L2_resp while in IDLE is ignored; no requester resp is produced.
- rst asserted in SERVE_*: next cycle is IDLE with all outputs 0. Any in-flight L2 response is dropped.

Test Plan:
- Single icache miss: icache_L2_read=1, address 0x1230, at cycle 0; L2_resp at cycle 4 with L2_rdata=0xA5...A5 -> L2_read=1 in cycles 1–4, L2_address=0x1230, icache_L2_resp=1 only in cycle 4, dcache_L2_resp=0 throughout.
- dcache write-back: dcache_L2_write=1, address 0x4440, wdata=0xDEAD_BEEF repeated -> L2_write=1 with that address and data; L2_read=0; dcache_L2_resp pulses with L2_resp.
- Contention after reset: both caches request at cycle 0 -> icache served first (prio=0); dcache granted in the IDLE cycle after icache's resp; the next simultaneous request goes to icache again.
- Address stability: change icache_L2_address to 0xFFFE during SERVE_I -> L2_address stays 0x1230 until resp.
- Reset mid-transaction: rst=1 in SERVE_D cycle 2 -> cycle 3: L2_read=L2_write=0, both resps 0, state IDLE, prio=0; a late L2_resp produces no requester resp.
- Stray L2_resp in IDLE: pulse L2_resp with no request outstanding -> icache_L2_resp=dcache_L2_resp=0.

Source files
------------

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: alternating-priority arbiter from icache/dcache onto a single L2 port
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_L2_read,
    input  logic [ADDR_WIDTH-1:0] icache_L2_address,
    output logic [LINE_WIDTH-1:0] icache_L2_rdata,
    output logic                  icache_L2_resp,
    input  logic                  dcache_L2_read,
    input  logic                  dcache_L2_write,
    input  logic [ADDR_WIDTH-1:0] dcache_L2_address,
    input  logic [LINE_WIDTH-1:0] dcache_L2_wdata,
    output logic [LINE_WIDTH-1:0] dcache_L2_rdata,
    output logic                  dcache_L2_resp,
    output logic                  L2_read,
    output logic                  L2_write,
    output logic [ADDR_WIDTH-1:0] L2_address,
    output logic [LINE_WIDTH-1:0] L2_wdata,
    input  logic [LINE_WIDTH-1:0] L2_rdata,
    input  logic                  L2_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  i_req, d_req, grant_i, grant_d;
    logic                  serve_i, serve_d, busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign i_req   = icache_L2_read;
    assign d_req   = dcache_L2_read | dcache_L2_write;
    assign grant_i = state_q == IDLE && i_req && (!d_req || !prio_q);
    assign grant_d = state_q == IDLE && d_req && (!i_req || prio_q);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (grant_i) begin
            state_d = SERVE_I;
            prio_d  = 1'b1;
            addr_d  = icache_L2_address;
        end else if (grant_d) begin
            state_d    = SERVE_D;
            prio_d     = 1'b0;
            addr_d     = dcache_L2_address;
            wdata_d    = dcache_L2_wdata;
            is_write_d = dcache_L2_write;
        end else if (state_q != IDLE && L2_resp) begin
            state_d = IDLE;
        end
    end

    // outputs are forced quiet during reset so an in-flight response is dropped
    always_comb begin
        busy            = state_q != IDLE && !rst;
        serve_i         = busy && state_q == SERVE_I;
        serve_d         = busy && state_q == SERVE_D;
        L2_read         = serve_i || (serve_d && !is_write_q);
        L2_write        = serve_d && is_write_q;
        L2_address      = busy ? addr_q : '0;
        L2_wdata        = serve_d ? wdata_q : '0;
        icache_L2_resp  = serve_i && L2_resp;
        dcache_L2_resp  = serve_d && L2_resp;
        icache_L2_rdata = busy ? L2_rdata : '0;
        dcache_L2_rdata = busy ? L2_rdata : '0;
    end
endmodule
